// File: rtl/enemy_formation_if.sv
// Bullet-check handshake plus the coordinate/visibility feed from the enemy formation controller.
// master = requester/consumer side, slave = formation controller.
interface enemy_formation_if;
  logic        hit_valid;
  logic        hit_ready;
  logic [7:0]  hit_x;
  logic [7:0]  hit_y;
  logic        hit_done;
  logic        hit_hit;
  logic [3:0]  hit_idx;
  logic [79:0] x_flat;
  logic [79:0] y_flat;
  logic [9:0]  visible;
  logic        load_coord;
  logic        all_dead;
  logic        reached_bottom;

  modport master (
    output hit_valid, hit_x, hit_y,
    input  hit_ready, hit_done, hit_hit, hit_idx,
    input  x_flat, y_flat, visible, load_coord, all_dead, reached_bottom
  );

  modport slave (
    input  hit_valid, hit_x, hit_y,
    output hit_ready, hit_done, hit_hit, hit_idx,
    output x_flat, y_flat, visible, load_coord, all_dead, reached_bottom
  );
endinterface

// File: rtl/enemy_formation_ctrl.sv
// Position/alive state of a 2x5 enemy formation: steps on frame ticks, resolves bullet
// hits by scanning one enemy per cycle, and strobes load_coord whenever coordinates change.
module enemy_formation_ctrl #(
  parameter logic [7:0] X_START  = 8'd20,
  parameter logic [7:0] Y_START  = 8'd10,
  parameter logic [7:0] SPACE_X  = 8'd12,
  parameter logic [7:0] SPACE_Y  = 8'd10,
  parameter logic [7:0] STEP     = 8'd2,
  parameter logic [7:0] DROP     = 8'd4,
  parameter int         MOVE_DIV = 4,
  parameter logic [7:0] X_MAX    = 8'd159,
  parameter logic [7:0] Y_LIMIT  = 8'd100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  enemy_formation_if.slave  bus
);

  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_MOVE, S_LOAD} state_t;

  function automatic logic [7:0] col_off(input logic [3:0] i);
    logic [7:0] c;
    c = (i >= 4'd5) ? {4'd0, i - 4'd5} : {4'd0, i};
    return c * SPACE_X;
  endfunction

  function automatic logic [7:0] row_off(input logic [3:0] i);
    return (i >= 4'd5) ? SPACE_Y : 8'd0;
  endfunction

  function automatic logic at_bottom(input logic [7:0] oy);
    return ({1'b0, oy} + {1'b0, SPACE_Y} + 9'd4) >= {1'b0, Y_LIMIT};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       ox_q, ox_d, oy_q, oy_d;
  logic             dir_q, dir_d;
  logic [9:0]       vis_q, vis_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_q, pend_d;
  logic             rb_q, rb_d;
  logic             hit_done_q, hit_done_d;
  logic             hit_hit_q, hit_hit_d;
  logic [3:0]       hit_idx_q, hit_idx_d;
  logic             load_q, load_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       hx_q, hx_d, hy_q, hy_d;

  logic [8:0]  scan_x, scan_y, hx9, hy9, redge;
  logic        match, bounce, all_dead;
  logic [79:0] x_flat_w, y_flat_w;

  assign all_dead = (vis_q == 10'd0);

  // Candidate enemy box for the current scan index, compared in 9 bits
  assign scan_x = {1'b0, ox_q} + {1'b0, col_off(idx_q)};
  assign scan_y = {1'b0, oy_q} + {1'b0, row_off(idx_q)};
  assign hx9    = {1'b0, hx_q};
  assign hy9    = {1'b0, hy_q};
  assign match  = vis_q[idx_q] && (hx9 >= scan_x) && (hx9 <= scan_x + 9'd4) &&
                  (hy9 >= scan_y) && (hy9 <= scan_y + 9'd4);

  // Edge test uses the full formation width regardless of which columns are alive
  assign redge  = {1'b0, ox_q} + {1'b0, SPACE_X} * 9'd4 + 9'd4 + {1'b0, STEP};
  assign bounce = dir_q ? (ox_q < STEP) : (redge > {1'b0, X_MAX});

  always_comb begin
    x_flat_w = '0;
    y_flat_w = '0;
    for (int i = 0; i < 10; i++) begin
      x_flat_w[8*i +: 8] = ox_q + col_off(4'(i));
      y_flat_w[8*i +: 8] = oy_q + row_off(4'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    dir_d      = dir_q;
    vis_d      = vis_q;
    div_d      = div_q;
    pend_d     = pend_q;
    rb_d       = rb_q;
    hit_done_d = 1'b0;
    hit_hit_d  = 1'b0;
    hit_idx_d  = hit_idx_q;
    idx_d      = idx_q;
    hx_d       = hx_q;
    hy_d       = hy_q;

    case (state_q)
      S_INIT: state_d = S_LOAD;
      S_IDLE: begin
        if (bus.hit_valid) begin
          state_d = S_SCAN;
          idx_d   = 4'd0;
          hx_d    = bus.hit_x;
          hy_d    = bus.hit_y;
        end else if (pend_q) begin
          state_d = S_MOVE;
        end
      end
      S_SCAN: begin
        if (match) begin
          vis_d[idx_q] = 1'b0;
          hit_done_d   = 1'b1;
          hit_hit_d    = 1'b1;
          hit_idx_d    = idx_q;
          state_d      = S_LOAD;
        end else if (idx_q == 4'd9) begin
          hit_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_MOVE: begin
        pend_d = 1'b0;
        if (all_dead || rb_q) begin
          state_d = S_IDLE;
        end else begin
          if (bounce) begin
            oy_d  = oy_q + DROP;
            dir_d = ~dir_q;
          end else if (dir_q) begin
            ox_d = ox_q - STEP;
          end else begin
            ox_d = ox_q + STEP;
          end
          if (at_bottom(oy_d)) rb_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    // A tick arriving with a step already pending is absorbed, not queued
    if (frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        pend_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    load_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      ox_q       <= X_START;
      oy_q       <= Y_START;
      dir_q      <= 1'b0;
      vis_q      <= 10'h3FF;
      div_q      <= '0;
      pend_q     <= 1'b0;
      rb_q       <= 1'b0;
      hit_done_q <= 1'b0;
      hit_hit_q  <= 1'b0;
      hit_idx_q  <= 4'd0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      dir_q      <= dir_d;
      vis_q      <= vis_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      rb_q       <= rb_d;
      hit_done_q <= hit_done_d;
      hit_hit_q  <= hit_hit_d;
      hit_idx_q  <= hit_idx_d;
      load_q     <= load_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    hx_q  <= hx_d;
    hy_q  <= hy_d;
  end

  assign bus.hit_ready      = (state_q == S_IDLE);
  assign bus.hit_done       = hit_done_q;
  assign bus.hit_hit        = hit_hit_q;
  assign bus.hit_idx        = hit_idx_q;
  assign bus.x_flat         = x_flat_w;
  assign bus.y_flat         = y_flat_w;
  assign bus.visible        = vis_q;
  assign bus.load_coord     = load_q;
  assign bus.all_dead       = all_dead;
  assign bus.reached_bottom = rb_q;

endmodule
